// File: rtl/ultrasonic_ranging_ctrl.sv
// ultrasonic_ranging_ctrl: sequences one ultrasonic ranging cycle at a time.
// Emits the trigger pulse, times the echo high width in clk cycles, and
// enforces the wait/echo timeout and the minimum trigger-to-trigger period.
module ultrasonic_ranging_ctrl #(
  parameter int TRIG_CYCLES    = 60,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int PERIOD_CYCLES  = 360000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [23:0] echo_cycles,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [23:0] TRIG_LAST = 24'(TRIG_CYCLES - 1);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] TO_MAX    = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] PER_LAST  = 24'(PERIOD_CYCLES - 1);
  localparam logic [23:0] CNT_SAT   = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [23:0] pcnt, pcnt_n;
  logic        echo_m, echo_s, echo_d;
  logic        rise, fall;
  logic        res_vld, res_to;
  logic [23:0] res_cyc;

  // Two-stage synchroniser for the raw echo, plus one delay stage for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  // Next-state, counter and result logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    // period counter runs in every non-IDLE state and saturates so a
    // stuck-high echo parked in HOLDOFF can never wrap it
    pcnt_n  = (pcnt == CNT_SAT) ? pcnt : pcnt + 24'd1;
    res_vld = 1'b0;
    res_to  = 1'b0;
    res_cyc = cnt;
    case (state)
      S_IDLE: begin
        pcnt_n = pcnt;
        if (start || auto_en) begin
          state_n = S_TRIG;
          cnt_n   = '0;
          pcnt_n  = '0;
        end
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_n = S_WAIT_RISE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      S_WAIT_RISE: begin
        if (rise) begin
          // the rising cycle itself is the first high cycle
          state_n = S_MEASURE;
          cnt_n   = 24'd1;
        end else if (cnt == TO_LAST) begin
          state_n = S_HOLDOFF;
          res_vld = 1'b1;
          res_to  = 1'b1;
          res_cyc = CNT_SAT;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      S_MEASURE: begin
        // fall takes priority over the width limit in the same cycle
        if (fall) begin
          state_n = S_HOLDOFF;
          res_vld = 1'b1;
        end else if (cnt == TO_MAX) begin
          state_n = S_HOLDOFF;
          res_vld = 1'b1;
          res_to  = 1'b1;
          res_cyc = CNT_SAT;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      S_HOLDOFF: begin
        if (pcnt >= PER_LAST && !echo_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      trig_out    <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      echo_cycles <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pcnt     <= pcnt_n;
      trig_out <= (state_n == S_TRIG);
      busy     <= (state_n != S_IDLE);
      valid    <= res_vld;
      if (res_vld) begin
        echo_cycles <= res_cyc;
        timeout     <= res_to;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranging_ctrl.sv
// tb_ultrasonic_ranging_ctrl: directed + randomized bench with an
// event-level reference model (expected widths, latencies, periods).
`timescale 1ns/1ps
module tb_ultrasonic_ranging_ctrl;

  localparam int TRIG = 4;
  localparam int TO   = 100;
  localparam int PER  = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        echo_in = 1'b0;
  logic        trig_out, valid, timeout, busy;
  logic [23:0] echo_cycles;

  ultrasonic_ranging_ctrl #(
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .echo_in(echo_in), .trig_out(trig_out), .echo_cycles(echo_cycles),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // event log, sampled 1ns after each rising edge; cyc = edges so far
  int          cyc = 0;
  int          n_tr = 0, last_tr = 0, n_tf = 0, last_tf = 0;
  int          n_v = 0, last_vc = 0, n_bf = 0, last_bf = 0;
  logic [23:0] last_vv = '0;
  logic        last_vto = 1'b0;
  logic        p_trig = 1'b0, p_busy = 1'b0;
  int          tr_hist[$];

  int tests = 0, fails = 0;
  int e_low, nb0, nv_exp;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (trig_out && !p_trig) begin n_tr++; last_tr = cyc; tr_hist.push_back(cyc); end
    if (!trig_out && p_trig) begin n_tf++; last_tf = cyc; end
    if (valid) begin n_v++; last_vc = cyc; last_vv = echo_cycles; last_vto = timeout; end
    if (!busy && p_busy) begin n_bf++; last_bf = cyc; end
    p_trig = trig_out;
    p_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_trig"},  trig_out, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_to"},    timeout, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_cyc"},   echo_cycles, 0);
  endtask

  task automatic wait_tf(input int n0);
    int k; k = 0;
    while (n_tf <= n0 && k < 2000) begin @(negedge clk); k++; end
    chk("wait_trig_fall", n_tf > n0, 1);
  endtask

  task automatic wait_tr(input int n0);
    int k; k = 0;
    while (n_tr <= n0 && k < 2000) begin @(negedge clk); k++; end
    chk("wait_trig_rise", n_tr > n0, 1);
  endtask

  task automatic wait_v(input int n0);
    int k; k = 0;
    while (n_v <= n0 && k < 2000) begin @(negedge clk); k++; end
    chk("wait_valid", n_v > n0, 1);
  endtask

  // One measurement: echo of 'width' cycles starting 'dly' cycles after the
  // trigger falls (width 0 = no echo); optional start poke mid-echo.
  task automatic shot(input int dly, input int width, input bit poke);
    int n0, nv0, tf, a, evc;
    logic [23:0] ev;
    n0 = n_tf; nv0 = n_v; nb0 = n_bf; e_low = 0; nv_exp = nv0 + 1;
    wait_tf(n0);
    chk("trig_len", last_tf - last_tr, TRIG);
    tf = last_tf;
    while (cyc < tf + dly) @(negedge clk);
    a = cyc;
    if (width > 0) begin
      echo_in = 1'b1;
      if (poke) begin tick(width / 2); go(); end
      while (cyc < a + width) @(negedge clk);
      echo_in = 1'b0;
      e_low = cyc;
      // 3-edge detection latency on each echo edge
      evc = a + ((width < TO) ? width : TO) + 3;
      ev  = (width < TO) ? 24'(width) : 24'hFFFFFF;
    end else begin
      evc = tf + TO;
      ev  = 24'hFFFFFF;
    end
    wait_v(nv0);
    chk("valid_cyc", last_vc, evc);
    chk("echo_cycles", last_vv, ev);
    chk("timeout_flag", last_vto, (width == 0 || width >= TO) ? 1 : 0);
  endtask

  // Wait for the block to go idle and check holdoff length and valid count
  task automatic settle();
    int k, ebf;
    k = 0;
    while (n_bf <= nb0 && k < 2000) begin @(negedge clk); k++; end
    chk("wait_busy_fall", n_bf > nb0, 1);
    ebf = (last_tr + PER > e_low + 3) ? last_tr + PER : e_low + 3;
    chk("busy_fall", last_bf, ebf);
    chk("single_valid", n_v, nv_exp);
  endtask

  initial begin
    int s, ntr0, nv0, w, d;
    // reset state
    tick(3);
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick(2);

    // single shot
    s = cyc;
    go();
    shot(10, 50, 0);
    chk("start_to_trig", last_tr, s + 1);
    settle();

    // no echo
    go(); shot(0, 0, 0); settle();
    // largest normally reported width
    go(); shot(5, TO - 1, 0); settle();
    // long echo, then stuck echo past the period
    go(); shot(10, 150, 0); settle();
    go(); shot(10, 350, 0);
    chk("stuck_busy", busy, 1);
    settle();

    // auto mode, three periods
    ntr0 = n_tr;
    auto_en = 1'b1;
    shot(10, 20, 0);
    shot(10, 40, 0);
    wait_tr(ntr0 + 2);
    auto_en = 1'b0;
    shot(10, 60, 0);
    settle();
    chk("auto_period1", tr_hist[ntr0 + 1] - tr_hist[ntr0], PER + 1);
    chk("auto_period2", tr_hist[ntr0 + 2] - tr_hist[ntr0 + 1], PER + 1);
    tick(50);
    chk("auto_stopped", n_tr, ntr0 + 3);

    // start while busy is ignored
    ntr0 = n_tr;
    go(); shot(10, 60, 1); settle();
    tick(20);
    chk("start_ignored", n_tr, ntr0 + 1);

    // reset mid-measure
    nv0 = n_v;
    go();
    wait_tf(n_tf);
    tick(5);
    echo_in = 1'b1;
    tick(20);
    rst = 1'b1;
    tick(1);
    chk_idle_outputs("midrst");
    echo_in = 1'b0;
    rst = 1'b0;
    tick(10);
    chk("no_partial_valid", n_v, nv0);
    go(); shot(7, 33, 0); settle();

    // randomized single shots
    for (int i = 0; i < 5; i++) begin
      w = $urandom_range(1, 140);
      if (w == TO) w = TO + 1;
      d = $urandom_range(0, 50);
      go(); shot(d, w, 0); settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
